// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared FSM encoding, default sizes and clog2 helper for the binary FC layer
package bnn_pkg;

  localparam int DEF_IN_W  = 400;
  localparam int DEF_N_OUT = 10;
  localparam int DEF_CHUNK = 50;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Constant-function ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bnn_popcount.sv
// rtl/bnn_popcount.sv - combinational popcount of a W-bit vector
module bnn_popcount
  import bnn_pkg::*;
#(
  parameter int W = DEF_CHUNK
) (
  input  logic [W-1:0]            data,
  output logic [clog2(W+1)-1:0]   count
);

  localparam int PC_W = clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PC_W'(data[i]);
    end
  end

endmodule

// File: rtl/bnn_fc_stream.sv
// rtl/bnn_fc_stream.sv - binary fully-connected layer, chunked XNOR/popcount with threshold and argmax
module bnn_fc_stream
  import bnn_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int N_OUT = DEF_N_OUT,
  parameter int CHUNK = DEF_CHUNK,
  parameter int CNT_W = clog2(IN_W + 1),
  parameter int IDX_W = clog2(N_OUT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic [N_OUT*IN_W-1:0]    weights,
  input  logic [N_OUT*CNT_W-1:0]   thresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT-1:0]         out_bits,
  output logic [N_OUT*CNT_W-1:0]   out_counts,
  output logic [IDX_W-1:0]         out_argmax,
  output logic                     busy
);

  localparam int N_CHUNK = IN_W / CHUNK;
  localparam int PC_W    = clog2(CHUNK + 1);
  localparam int CI_W    = (N_CHUNK > 1) ? clog2(N_CHUNK) : 1;

  logic [1:0]             state, state_next;
  logic [IN_W-1:0]        in_reg;
  logic [CI_W-1:0]        chunk_idx;
  logic [CNT_W-1:0]       acc [N_OUT];
  logic [PC_W-1:0]        chunk_pc [N_OUT];
  logic [CHUNK-1:0]       in_chunk;
  logic [N_OUT-1:0]       bits_next;
  logic [N_OUT*CNT_W-1:0] acc_flat;
  logic [IDX_W-1:0]       argmax_next;
  logic [CNT_W-1:0]       best_cnt;
  logic                   accept;
  logic                   last_chunk;

  assign in_chunk   = in_reg[int'(chunk_idx)*CHUNK +: CHUNK];
  assign accept     = in_valid && in_ready;
  assign last_chunk = (chunk_idx == CI_W'(N_CHUNK - 1));

  for (genvar n = 0; n < N_OUT; n++) begin : g_neuron
    logic [CHUNK-1:0] w_chunk;
    logic [CHUNK-1:0] agree;

    assign w_chunk = weights[n*IN_W + int'(chunk_idx)*CHUNK +: CHUNK];
    assign agree   = ~(in_chunk ^ w_chunk);

    bnn_popcount #(.W(CHUNK)) u_popcount (
      .data  (agree),
      .count (chunk_pc[n])
    );

    assign bits_next[n]                 = (acc[n] >= thresh[n*CNT_W +: CNT_W]);
    assign acc_flat[n*CNT_W +: CNT_W]   = acc[n];
  end

  // Strict '>' keeps the earliest index on ties.
  always_comb begin
    best_cnt    = acc[0];
    argmax_next = '0;
    for (int n = 1; n < N_OUT; n++) begin
      if (acc[n] > best_cnt) begin
        best_cnt    = acc[n];
        argmax_next = IDX_W'(n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (in_valid)   state_next = ST_ACCUM;
      ST_ACCUM:  if (last_chunk) state_next = ST_DECIDE;
      ST_DECIDE:                 state_next = ST_HOLD;
      ST_HOLD:   if (out_ready)  state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_HOLD);
    busy      = (state == ST_ACCUM) || (state == ST_DECIDE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg     <= '0;
      chunk_idx  <= '0;
      out_bits   <= '0;
      out_counts <= '0;
      out_argmax <= '0;
      for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_reg    <= in_data;
            chunk_idx <= '0;
            for (int n = 0; n < N_OUT; n++) acc[n] <= '0;
          end
        end
        ST_ACCUM: begin
          for (int n = 0; n < N_OUT; n++) acc[n] <= acc[n] + CNT_W'(chunk_pc[n]);
          chunk_idx <= chunk_idx + 1'b1;
        end
        ST_DECIDE: begin
          out_counts <= acc_flat;
          out_bits   <= bits_next;
          out_argmax <= argmax_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_fc_stream.sv
// tb/tb_bnn_fc_stream.sv - randomized self-checking bench for bnn_fc_stream against a popcount model
`timescale 1ns/1ps
module tb_bnn_fc_stream;

  localparam int IN_W    = 400;
  localparam int N_OUT   = 10;
  localparam int CHUNK   = 50;
  localparam int CNT_W   = 9;
  localparam int IDX_W   = 4;
  localparam int N_CHUNK = IN_W / CHUNK;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid, in_ready, out_valid, out_ready, busy;
  logic [IN_W-1:0]        in_data;
  logic [N_OUT*IN_W-1:0]  weights;
  logic [N_OUT*CNT_W-1:0] thresh;
  logic [N_OUT-1:0]       out_bits;
  logic [N_OUT*CNT_W-1:0] out_counts;
  logic [IDX_W-1:0]       out_argmax;

  logic                   in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [N_OUT-1:0]       out_bits1;
  logic [N_OUT*CNT_W-1:0] out_counts1;
  logic [IDX_W-1:0]       out_argmax1;

  logic [N_OUT*CNT_W-1:0] exp_counts;
  logic [N_OUT-1:0]       exp_bits;
  logic [IDX_W-1:0]       exp_argmax;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bnn_fc_stream #(.IN_W(IN_W), .N_OUT(N_OUT), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .weights(weights), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_counts(out_counts), .out_argmax(out_argmax),
    .busy(busy)
  );

  bnn_fc_stream #(.IN_W(IN_W), .N_OUT(N_OUT), .CHUNK(IN_W)) dut_one (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .weights(weights), .thresh(thresh),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_bits(out_bits1), .out_counts(out_counts1), .out_argmax(out_argmax1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: count = agreements = IN_W - hamming distance; first maximum wins.
  task automatic compute_model();
    int best;
    best = -1;
    for (int n = 0; n < N_OUT; n++) begin
      int c;
      c = IN_W - $countones(in_data ^ weights[n*IN_W +: IN_W]);
      exp_counts[n*CNT_W +: CNT_W] = CNT_W'(c);
      exp_bits[n] = (c >= int'(thresh[n*CNT_W +: CNT_W]));
      if (c > best) begin
        best       = c;
        exp_argmax = IDX_W'(n);
      end
    end
  endtask

  function automatic logic [IN_W-1:0] rand_vec();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic randomize_all(input int th_max);
    in_data = rand_vec();
    for (int n = 0; n < N_OUT; n++) begin
      weights[n*IN_W +: IN_W]   = rand_vec();
      thresh[n*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, th_max));
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, in_ready, 1);
  endtask

  // Entered at the negedge right after the accepting edge.
  task automatic finish_check(input string tag);
    int lat;
    lat = 0;
    check({tag, "_busy"}, busy, 1);
    while (!out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, N_CHUNK + 1);
    check({tag, "_counts"}, out_counts, exp_counts);
    check({tag, "_bits"}, out_bits, exp_bits);
    check({tag, "_argmax"}, out_argmax, exp_argmax);
    check({tag, "_hold_rdy"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, out_valid, 0);
    check({tag, "_rdy_back"}, in_ready, 1);
    check({tag, "_keep"}, out_counts, exp_counts);
  endtask

  task automatic send_and_check(input string tag);
    compute_model();
    wait_ready(tag);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    finish_check(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0]        mask;
    logic [IN_W-1:0]        vec_b;
    logic [N_OUT*CNT_W-1:0] a_counts;
    int                     vld_seen;
    int                     lat1;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    in_data = '0; weights = '0; thresh = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_bits", out_bits, 0);
    check("rst_counts", out_counts, 0);
    check("rst_argmax", out_argmax, 0);

    // All agree: every neuron saturates.
    in_data = '1; weights = '1;
    for (int n = 0; n < N_OUT; n++) thresh[n*CNT_W +: CNT_W] = CNT_W'(200);
    send_and_check("allones");
    check("allones_bits_const", out_bits, 10'h3FF);
    check("allones_cnt0_const", out_counts[CNT_W-1:0], 400);

    // Only neuron 7 matches.
    in_data = rand_vec();
    for (int n = 0; n < N_OUT; n++)
      weights[n*IN_W +: IN_W] = (n == 7) ? in_data : ~in_data;
    send_and_check("one_hot");
    check("one_hot_bits_const", out_bits, 10'h080);
    check("one_hot_argmax_const", out_argmax, 7);

    // Threshold boundary at count 200.
    randomize_all(IN_W);
    mask = '0;
    for (int i = 0; i < 200; i++) mask[i] = 1'b1;
    weights[2*IN_W +: IN_W] = in_data ^ mask;
    thresh[2*CNT_W +: CNT_W] = CNT_W'(200);
    send_and_check("thr200");
    check("thr200_bit2", out_bits[2], 1);
    thresh[2*CNT_W +: CNT_W] = CNT_W'(201);
    send_and_check("thr201");
    check("thr201_bit2", out_bits[2], 0);

    // Backpressure with in_valid held high.
    randomize_all(IN_W);
    compute_model();
    a_counts = exp_counts;
    wait_ready("bp");
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    vec_b = rand_vec();
    in_data = vec_b;
    vld_seen = 0;
    while (!out_valid && vld_seen < 40) begin
      @(posedge clk); @(negedge clk);
      vld_seen++;
    end
    check("bp_latency", vld_seen, N_CHUNK + 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_ready", in_ready, 0);
      check("bp_stall_counts", out_counts, a_counts);
    end
    compute_model();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("bp_second_ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    finish_check("bp_second");

    // Reset in the middle of accumulation.
    randomize_all(IN_W);
    wait_ready("midrst");
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    vld_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) vld_seen++;
    end
    check("midrst_no_pulse", vld_seen, 0);
    randomize_all(IN_W);
    send_and_check("midrst_fresh");

    // Tie between neurons 3 and 5 at the maximum.
    randomize_all(IN_W);
    weights[3*IN_W +: IN_W] = in_data;
    weights[5*IN_W +: IN_W] = in_data;
    send_and_check("tie");
    check("tie_argmax_const", out_argmax, 3);

    for (int r = 0; r < 6; r++) begin
      randomize_all(IN_W + 40);
      if (r == 0) thresh[0 +: CNT_W] = '0;
      send_and_check("random");
    end

    // Single-chunk instance: latency 2.
    randomize_all(IN_W);
    compute_model();
    check("one_ready", in_ready1, 1);
    in_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid1 = 1'b0;
    lat1 = 0;
    while (!out_valid1 && lat1 < 20) begin
      @(posedge clk); @(negedge clk);
      lat1++;
    end
    check("one_latency", lat1, 2);
    check("one_counts", out_counts1, exp_counts);
    check("one_bits", out_bits1, exp_bits);
    check("one_argmax", out_argmax1, exp_argmax);
    out_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready1 = 1'b0;
    check("one_vld_drop", out_valid1, 0);
    check("one_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
